instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 36 +++
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - host/processor-facing signals of the instruction sequencer.
// Optional step input exists only when SEQ_STEP_EN is defined.
interface instr_sequencer_if #(
  parameter int PC_W = 4
);
  logic            start;
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [31:0]     load_data;
`ifdef SEQ_STEP_EN
  logic            step;
`endif
  logic [31:0]     instr;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [7:0]      icount;

  modport master (
`ifdef SEQ_STEP_EN
    output step,
`endif
    output start, load_en, load_addr, load_data,
    input  instr, instr_valid, pc, busy, done, illegal, icount
  );

  modport slave (
`ifdef SEQ_STEP_EN
    input  step,
`endif
    input  start, load_en, load_addr, load_data,
    output instr, instr_valid, pc, busy, done, illegal, icount
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetches words from a host-loaded store and issues them to the processor.
// Define SEQ_STEP_EN to make FETCH->ISSUE wait on the step input (single-step debug).
module instr_sequencer #(
  parameter int IMEM_DEPTH = 16,
  parameter int PC_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  instr_sequencer_if.slave  bus
);
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SW   = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_HOLD, S_HALT} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [31:0]     instr_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic            illegal_q;
  logic [7:0]      icount_q;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [31:0]     fetch_word;
  logic [5:0]      fetch_op;
  logic            last_slot;
  logic [7:0]      icount_d;
  logic            step_ok;

  assign fetch_word = imem[pc_q];
  assign fetch_op   = fetch_word[31:26];
  assign last_slot  = (pc_q == PC_W'(IMEM_DEPTH - 1));
  assign icount_d   = (icount_q == 8'hFF) ? icount_q : icount_q + 8'd1;

`ifdef SEQ_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  // The store has no reset so a program survives rst; host writes are locked out while running.
  always_ff @(posedge clk) begin
    if (bus.load_en && !busy_q) begin
      imem[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            icount_q  <= '0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_q <= fetch_word;
          case (fetch_op)
            OP_ADD, OP_SW, OP_LW: begin
              if (step_ok) begin
                state_q <= S_ISSUE;
                instr_q <= fetch_word;
                valid_q <= 1'b1;
              end
            end
            OP_HALT: begin
              state_q <= S_HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: begin
              // nop and unknown opcodes are skipped; only unknown ones flag illegal
              if (fetch_op != OP_NOP) illegal_q <= 1'b1;
              if (last_slot) begin
                state_q <= S_HALT;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                pc_q <= pc_q + PC_W'(1);
              end
            end
          endcase
        end
        S_ISSUE, S_HOLD: begin
          if (state_q == S_ISSUE && ir_q[31:26] == OP_LW) begin
            state_q <= S_HOLD;
            instr_q <= ir_q;
          end else begin
            instr_q  <= '0;
            valid_q  <= 1'b0;
            icount_q <= icount_d;
            if (last_slot) begin
              state_q <= S_HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q    <= pc_q + PC_W'(1);
              state_q <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          if (bus.start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.icount      = icount_q;
endmodule
